// File: rtl/mem_stage.sv
// EX/MEM pipeline register, data-memory access with configurable wait states,
// branch resolution and the MEM/WB register feeding writeback.
module mem_stage #(
    parameter int unsigned WORD        = 64,
    parameter int unsigned MEM_DEPTH   = 64,
    parameter int unsigned MEM_LATENCY = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic [WORD-1:0] ex_alu_result,
    input  logic            ex_zero,
    input  logic [WORD-1:0] ex_write_data,
    input  logic [WORD-1:0] ex_branch_target,
    input  logic            ex_branch,
    input  logic            ex_uncond_branch,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic            ex_mem_to_reg,
    input  logic            ex_reg_write,
    input  logic [4:0]      ex_write_reg,
    input  logic            flush,
    output logic            stall,
    output logic            pc_src,
    output logic [WORD-1:0] branch_target,
    output logic            wb_valid,
    output logic [WORD-1:0] wb_read_data,
    output logic [WORD-1:0] wb_alu_result,
    output logic [4:0]      wb_write_reg,
    output logic            wb_reg_write,
    output logic            wb_mem_to_reg
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LAT = CW'(MEM_LATENCY);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;

    logic            m_valid_q, m_valid_d;
    logic [WORD-1:0] m_alu_result_q, m_alu_result_d;
    logic            m_zero_q, m_zero_d;
    logic [WORD-1:0] m_write_data_q, m_write_data_d;
    logic [WORD-1:0] m_branch_target_q, m_branch_target_d;
    logic            m_branch_q, m_branch_d;
    logic            m_uncond_branch_q, m_uncond_branch_d;
    logic            m_mem_read_q, m_mem_read_d;
    logic            m_mem_write_q, m_mem_write_d;
    logic            m_mem_to_reg_q, m_mem_to_reg_d;
    logic            m_reg_write_q, m_reg_write_d;
    logic [4:0]      m_write_reg_q, m_write_reg_d;

    logic            wb_valid_q, wb_valid_d;
    logic [WORD-1:0] wb_read_data_q, wb_read_data_d;
    logic [WORD-1:0] wb_alu_result_q, wb_alu_result_d;
    logic [4:0]      wb_write_reg_q, wb_write_reg_d;
    logic            wb_reg_write_q, wb_reg_write_d;
    logic            wb_mem_to_reg_q, wb_mem_to_reg_d;

    logic [WORD-1:0] mem_q [MEM_DEPTH];

    logic            mem_op_c;
    logic            stall_c;
    logic            live_c;
    logic            store_c;
    logic            load_c;
    logic [AW-1:0]   idx_c;

    // Memory-op decode, stall and completion qualifiers for the op held in EX/MEM
    always_comb begin
        mem_op_c = m_valid_q & (m_mem_read_q | m_mem_write_q);
        stall_c  = mem_op_c & (count_q != LAT);
        live_c   = m_valid_q & ~flush;
        store_c  = mem_op_c & ~stall_c & ~flush & m_mem_write_q;
        load_c   = mem_op_c & ~stall_c & ~flush & m_mem_read_q & ~m_mem_write_q;
        idx_c    = m_alu_result_q[AW+2:3];
    end

    // Wait-state FSM: counts cycles an op has been held until it reaches the latency
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (flush) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (stall_c) begin
                        state_d = WAIT;
                        count_d = count_q + CW'(1);
                    end
                end
                WAIT: begin
                    if (stall_c) begin
                        count_d = count_q + CW'(1);
                    end else begin
                        state_d = IDLE;
                        count_d = '0;
                    end
                end
            endcase
        end
    end

    // EX/MEM register: load when not stalled, flush kills the held instruction
    always_comb begin
        m_valid_d         = m_valid_q;
        m_alu_result_d    = m_alu_result_q;
        m_zero_d          = m_zero_q;
        m_write_data_d    = m_write_data_q;
        m_branch_target_d = m_branch_target_q;
        m_branch_d        = m_branch_q;
        m_uncond_branch_d = m_uncond_branch_q;
        m_mem_read_d      = m_mem_read_q;
        m_mem_write_d     = m_mem_write_q;
        m_mem_to_reg_d    = m_mem_to_reg_q;
        m_reg_write_d     = m_reg_write_q;
        m_write_reg_d     = m_write_reg_q;
        if (!stall_c) begin
            m_valid_d         = ex_valid;
            m_alu_result_d    = ex_alu_result;
            m_zero_d          = ex_zero;
            m_write_data_d    = ex_write_data;
            m_branch_target_d = ex_branch_target;
            m_branch_d        = ex_branch;
            m_uncond_branch_d = ex_uncond_branch;
            m_mem_read_d      = ex_mem_read;
            m_mem_write_d     = ex_mem_write;
            m_mem_to_reg_d    = ex_mem_to_reg;
            m_reg_write_d     = ex_reg_write;
            m_write_reg_d     = ex_write_reg;
        end
        if (flush) begin
            m_valid_d = 1'b0;
        end
    end

    // MEM/WB register: bubble while stalled, otherwise advance the EX/MEM instruction
    always_comb begin
        wb_valid_d      = wb_valid_q;
        wb_read_data_d  = wb_read_data_q;
        wb_alu_result_d = wb_alu_result_q;
        wb_write_reg_d  = wb_write_reg_q;
        wb_reg_write_d  = wb_reg_write_q;
        wb_mem_to_reg_d = wb_mem_to_reg_q;
        if (stall_c) begin
            wb_valid_d     = 1'b0;
            wb_reg_write_d = 1'b0;
        end else begin
            wb_valid_d      = live_c;
            wb_alu_result_d = m_alu_result_q;
            wb_write_reg_d  = m_write_reg_q;
            wb_mem_to_reg_d = m_mem_to_reg_q;
            wb_reg_write_d  = m_reg_write_q & live_c;
            if (load_c) begin
                wb_read_data_d = mem_q[idx_c];
            end
        end
    end

    // State, pipeline registers and data memory
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            count_q           <= '0;
            m_valid_q         <= 1'b0;
            m_alu_result_q    <= '0;
            m_zero_q          <= 1'b0;
            m_write_data_q    <= '0;
            m_branch_target_q <= '0;
            m_branch_q        <= 1'b0;
            m_uncond_branch_q <= 1'b0;
            m_mem_read_q      <= 1'b0;
            m_mem_write_q     <= 1'b0;
            m_mem_to_reg_q    <= 1'b0;
            m_reg_write_q     <= 1'b0;
            m_write_reg_q     <= '0;
            wb_valid_q        <= 1'b0;
            wb_read_data_q    <= '0;
            wb_alu_result_q   <= '0;
            wb_write_reg_q    <= '0;
            wb_reg_write_q    <= 1'b0;
            wb_mem_to_reg_q   <= 1'b0;
            for (int i = 0; i < int'(MEM_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q           <= state_d;
            count_q           <= count_d;
            m_valid_q         <= m_valid_d;
            m_alu_result_q    <= m_alu_result_d;
            m_zero_q          <= m_zero_d;
            m_write_data_q    <= m_write_data_d;
            m_branch_target_q <= m_branch_target_d;
            m_branch_q        <= m_branch_d;
            m_uncond_branch_q <= m_uncond_branch_d;
            m_mem_read_q      <= m_mem_read_d;
            m_mem_write_q     <= m_mem_write_d;
            m_mem_to_reg_q    <= m_mem_to_reg_d;
            m_reg_write_q     <= m_reg_write_d;
            m_write_reg_q     <= m_write_reg_d;
            wb_valid_q        <= wb_valid_d;
            wb_read_data_q    <= wb_read_data_d;
            wb_alu_result_q   <= wb_alu_result_d;
            wb_write_reg_q    <= wb_write_reg_d;
            wb_reg_write_q    <= wb_reg_write_d;
            wb_mem_to_reg_q   <= wb_mem_to_reg_d;
            if (store_c) begin
                mem_q[idx_c] <= m_write_data_q;
            end
        end
    end

    assign stall         = stall_c;
    assign pc_src        = live_c & (m_uncond_branch_q | (m_branch_q & m_zero_q));
    assign branch_target = m_branch_target_q;
    assign wb_valid      = wb_valid_q;
    assign wb_read_data  = wb_read_data_q;
    assign wb_alu_result = wb_alu_result_q;
    assign wb_write_reg  = wb_write_reg_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign wb_mem_to_reg = wb_mem_to_reg_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: three instances (latency 0, 2, 3), directed sequences,
// a vector table for branch/ALU flow and a randomized scoreboard run.
module tb_mem_stage;

    typedef struct {
        logic        valid;
        logic [63:0] alu;
        logic [63:0] wdata;
        logic [63:0] tgt;
        logic        zero;
        logic        br;
        logic        ub;
        logic        rd;
        logic        wr;
        logic        m2r;
        logic        rw;
        logic [4:0]  wreg;
    } ex_t;

    typedef struct {
        ex_t  e;
        logic exp_pc;
        logic exp_wv;
        logic exp_rw;
    } vec_t;

    typedef struct {
        ex_t         e;
        logic [63:0] rdata;
        int          issue;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    ex_t  ex;
    int   sel;

    logic        stall_o [3];
    logic        pc_src_o [3];
    logic [63:0] bt_o [3];
    logic        wv_o [3];
    logic [63:0] rd_o [3];
    logic [63:0] alu_o [3];
    logic [4:0]  wr_o [3];
    logic        rw_o [3];
    logic        m2r_o [3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_stage #(
            .WORD(64),
            .MEM_DEPTH(64),
            .MEM_LATENCY((g == 0) ? 0 : ((g == 1) ? 2 : 3))
        ) u_dut (
            .clk              (clk),
            .reset            (reset),
            .ex_valid         (ex.valid && (sel == g)),
            .ex_alu_result    (ex.alu),
            .ex_zero          (ex.zero),
            .ex_write_data    (ex.wdata),
            .ex_branch_target (ex.tgt),
            .ex_branch        (ex.br),
            .ex_uncond_branch (ex.ub),
            .ex_mem_read      (ex.rd),
            .ex_mem_write     (ex.wr),
            .ex_mem_to_reg    (ex.m2r),
            .ex_reg_write     (ex.rw),
            .ex_write_reg     (ex.wreg),
            .flush            (flush && (sel == g)),
            .stall            (stall_o[g]),
            .pc_src           (pc_src_o[g]),
            .branch_target    (bt_o[g]),
            .wb_valid         (wv_o[g]),
            .wb_read_data     (rd_o[g]),
            .wb_alu_result    (alu_o[g]),
            .wb_write_reg     (wr_o[g]),
            .wb_reg_write     (rw_o[g]),
            .wb_mem_to_reg    (m2r_o[g])
        );
    end

    function automatic int lat_of(input int s);
        return (s == 0) ? 0 : ((s == 1) ? 2 : 3);
    endfunction

    function automatic ex_t mk(input logic v, input logic [63:0] alu, input logic [63:0] wd,
                               input logic [63:0] tgt, input logic z, input logic br,
                               input logic ub, input logic rd, input logic wr,
                               input logic m2r, input logic rw, input logic [4:0] wreg);
        ex_t e;
        e.valid = v;   e.alu = alu;  e.wdata = wd; e.tgt = tgt;
        e.zero  = z;   e.br  = br;   e.ub    = ub; e.rd  = rd;
        e.wr    = wr;  e.m2r = m2r;  e.rw    = rw; e.wreg = wreg;
        return e;
    endfunction

    function automatic ex_t bubble();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic ex_t st(input logic [63:0] a, input logic [63:0] d);
        return mk(1, a, d, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    endfunction
    function automatic ex_t ld(input logic [63:0] a, input logic [4:0] r);
        return mk(1, a, 0, 0, 0, 0, 0, 1, 0, 1, 1, r);
    endfunction
    function automatic ex_t add(input logic [63:0] a, input logic [4:0] r);
        return mk(1, a, 0, 0, 0, 0, 0, 0, 0, 0, 1, r);
    endfunction
    function automatic vec_t mv(input ex_t e, input logic p, input logic w, input logic r);
        vec_t v;
        v.e = e; v.exp_pc = p; v.exp_wv = w; v.exp_rw = r;
        return v;
    endfunction

    function automatic ex_t rand_ex();
        ex_t e;
        int  kind;
        logic [63:0] a;
        kind = int'($urandom_range(0, 4));
        a = {32'($urandom), 32'($urandom)};
        a = (a & ~64'h1F8) | (64'($urandom_range(0, 7)) << 3);
        e = mk(($urandom_range(0, 99) < 85), a, {32'($urandom), 32'($urandom)},
               {32'($urandom), 32'($urandom)}, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0,
               1'($urandom), 1'($urandom), 5'($urandom));
        case (kind)
            1: e.rd = 1'b1;
            2: e.wr = 1'b1;
            3: begin e.rd = 1'b1; e.wr = 1'b1; end
            4: begin e.br = 1'($urandom); e.ub = ~e.br; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        ex = bubble();
        flush = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic chk_zero(input int s, input string tag);
        chk({tag, "_stall"}, 64'(stall_o[s]), 0);
        chk({tag, "_pc_src"}, 64'(pc_src_o[s]), 0);
        chk({tag, "_bt"}, bt_o[s], 0);
        chk({tag, "_wv"}, 64'(wv_o[s]), 0);
        chk({tag, "_rdata"}, rd_o[s], 0);
        chk({tag, "_alu"}, alu_o[s], 0);
        chk({tag, "_wreg"}, 64'(wr_o[s]), 0);
        chk({tag, "_rw"}, 64'(rw_o[s]), 0);
        chk({tag, "_m2r"}, 64'(m2r_o[s]), 0);
    endtask

    // Steps until wb_valid rises; an expired budget is a failed comparison
    task automatic wait_wb(input int max, input string name);
        logic found = 1'b0;
        for (int i = 0; i < max; i++) begin
            step();
            if (wv_o[sel]) begin
                found = 1'b1;
                break;
            end
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL %s: got no wb_valid expected one within %0d cycles", name, max);
        end
    endtask

    // Random traffic against an in-order transaction model with program-order memory
    task automatic rand_run(input int s, input int n);
        ex_t         cur;
        ex_t         res;
        exp_t        x;
        exp_t        q[$];
        logic [63:0] mmem [64];
        int          age = 0;
        int          cyc = 0;
        int          lat = lat_of(s);
        int          idx;
        logic        exp_stall;
        logic        exp_pc;
        logic        acc;
        sel = s;
        do_reset();
        for (int i = 0; i < 64; i++) mmem[i] = '0;
        res = bubble();
        cur = rand_ex();
        ex  = cur;
        for (int c = 0; c < n + 30; c++) begin
            exp_stall = res.valid && (res.rd || res.wr) && (age < lat);
            exp_pc    = res.valid && (res.ub || (res.br && res.zero));
            chk("rand_stall", 64'(stall_o[s]), 64'(exp_stall));
            chk("rand_pc_src", 64'(pc_src_o[s]), 64'(exp_pc));
            if (exp_pc) chk("rand_branch_target", bt_o[s], res.tgt);
            if (wv_o[s]) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL rand_wb_extra: got wb_valid=1 expected no pending instruction");
                end else begin
                    x = q.pop_front();
                    chk("rand_wb_alu", alu_o[s], x.e.alu);
                    chk("rand_wb_wreg", 64'(wr_o[s]), 64'(x.e.wreg));
                    chk("rand_wb_rw", 64'(rw_o[s]), 64'(x.e.rw));
                    chk("rand_wb_m2r", 64'(m2r_o[s]), 64'(x.e.m2r));
                    chk("rand_latency", 64'(cyc - x.issue), 64'(1 + x.lat));
                    if (x.e.rd && !x.e.wr) chk("rand_wb_rdata", rd_o[s], x.rdata);
                end
            end else begin
                chk("rand_wb_rw_idle", 64'(rw_o[s]), 0);
            end
            acc = !exp_stall;
            @(posedge clk);
            cyc++;
            if (acc) begin
                if (cur.valid) begin
                    idx = int'((cur.alu / 8) % 64);
                    x.e     = cur;
                    x.rdata = mmem[idx];
                    x.issue = cyc;
                    x.lat   = (cur.rd || cur.wr) ? lat : 0;
                    if (cur.wr) mmem[idx] = cur.wdata;
                    q.push_back(x);
                end
                res = cur;
                age = 0;
            end else begin
                age++;
            end
            #1;
            if (acc) begin
                cur = (c < n) ? rand_ex() : bubble();
                ex  = cur;
            end
            @(negedge clk);
        end
        chk("rand_drain", 64'(q.size()), 0);
    endtask

    vec_t vt [6];

    initial begin
        vt[0] = mv(mk(1, 64'h100, 0, 64'h40, 1, 1, 0, 0, 0, 0, 0, 5'd0), 1, 1, 0);
        vt[1] = mv(mk(1, 64'h104, 0, 64'h40, 0, 1, 0, 0, 0, 0, 0, 5'd0), 0, 1, 0);
        vt[2] = mv(mk(1, 64'h108, 0, 64'h80, 0, 0, 1, 0, 0, 0, 0, 5'd0), 1, 1, 0);
        vt[3] = mv(mk(1, 64'h1234, 0, 64'h0, 0, 0, 0, 0, 0, 0, 1, 5'd5), 0, 1, 1);
        vt[4] = mv(mk(0, 64'h55, 0, 64'hC0, 1, 0, 1, 0, 0, 0, 1, 5'd9), 0, 0, 0);
        vt[5] = mv(mk(1, 64'h77, 0, 64'h44, 0, 1, 0, 0, 0, 0, 0, 5'd3), 0, 1, 0);

        sel = 0;
        do_reset();
        for (int g = 0; g < 3; g++) chk_zero(g, "reset");

        // Latency 0: store then load the same doubleword
        sel = 0;
        ex = st(64'h10, 64'hDEADBEEF_00000001);
        step();
        chk("l0_st_stall", 64'(stall_o[0]), 0);
        ex = ld(64'h10, 5'd3);
        step();
        chk("l0_ld_stall", 64'(stall_o[0]), 0);
        chk("l0_st_wv", 64'(wv_o[0]), 1);
        chk("l0_st_rw", 64'(rw_o[0]), 0);
        ex = bubble();
        step();
        chk("l0_ld_stall2", 64'(stall_o[0]), 0);
        chk("l0_ld_wv", 64'(wv_o[0]), 1);
        chk("l0_ld_rdata", rd_o[0], 64'hDEADBEEF_00000001);
        chk("l0_ld_m2r", 64'(m2r_o[0]), 1);
        chk("l0_ld_wreg", 64'(wr_o[0]), 3);

        // Branch / ALU vector table
        foreach (vt[i]) begin
            ex = vt[i].e;
            step();
            chk("vec_pc_src", 64'(pc_src_o[0]), 64'(vt[i].exp_pc));
            if (vt[i].exp_pc) chk("vec_branch_target", bt_o[0], vt[i].e.tgt);
            ex = bubble();
            step();
            chk("vec_pc_src_drop", 64'(pc_src_o[0]), 0);
            chk("vec_wv", 64'(wv_o[0]), 64'(vt[i].exp_wv));
            chk("vec_rw", 64'(rw_o[0]), 64'(vt[i].exp_rw));
            chk("vec_alu", alu_o[0], vt[i].e.alu);
        end

        // Address wrap and ignored low bits
        ex = st(64'h218, 64'hCAFE_F00D_1234_5678);
        step();
        ex = ld(64'h1B, 5'd9);
        step();
        ex = bubble();
        step();
        chk("wrap_wv", 64'(wv_o[0]), 1);
        chk("wrap_rdata", rd_o[0], 64'hCAFE_F00D_1234_5678);

        // Latency 3: store, then a single load with an upstream-held ADD
        sel = 2;
        ex = st(64'h20, 64'h0123_4567_89AB_CDEF);
        step();
        ex = bubble();
        for (int i = 0; i < 10 && stall_o[2]; i++) step();
        step();
        chk("l3_pre_stall", 64'(stall_o[2]), 0);
        ex = ld(64'h20, 5'd4);
        step();
        ex = add(64'h777, 5'd6);
        for (int i = 0; i < 3; i++) begin
            chk("l3_stall_hi", 64'(stall_o[2]), 1);
            chk("l3_bubble_wv", 64'(wv_o[2]), 0);
            chk("l3_bubble_rw", 64'(rw_o[2]), 0);
            step();
        end
        chk("l3_stall_lo", 64'(stall_o[2]), 0);
        chk("l3_wait_wv", 64'(wv_o[2]), 0);
        step();
        chk("l3_ld_wv", 64'(wv_o[2]), 1);
        chk("l3_ld_rdata", rd_o[2], 64'h0123_4567_89AB_CDEF);
        chk("l3_ld_wreg", 64'(wr_o[2]), 4);
        chk("l3_add_nostall", 64'(stall_o[2]), 0);
        ex = bubble();
        step();
        chk("l3_add_wv", 64'(wv_o[2]), 1);
        chk("l3_add_alu", alu_o[2], 64'h777);
        chk("l3_add_wreg", 64'(wr_o[2]), 6);
        step();
        chk("l3_idle_wv", 64'(wv_o[2]), 0);

        // Latency 2: flush a store during its wait
        sel = 1;
        ex = st(64'h8, 64'h55);
        step();
        chk("fl_stall0", 64'(stall_o[1]), 1);
        ex = bubble();
        step();
        chk("fl_stall1", 64'(stall_o[1]), 1);
        chk("fl_wv1", 64'(wv_o[1]), 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_stall_drop", 64'(stall_o[1]), 0);
        chk("fl_wv2", 64'(wv_o[1]), 0);
        step();
        chk("fl_wv3", 64'(wv_o[1]), 0);
        ex = ld(64'h8, 5'd2);
        step();
        ex = bubble();
        wait_wb(8, "fl_ld_timeout");
        chk("fl_ld_rdata", rd_o[1], 0);

        // Latency 3: reset during a store's wait
        sel = 2;
        ex = st(64'h30, 64'hABCD);
        step();
        ex = bubble();
        step();
        chk("rst_pre_stall", 64'(stall_o[2]), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_zero(2, "rst_mid");
        ex = add(64'h1234, 5'd7);
        step();
        ex = bubble();
        chk("rst_add_wv0", 64'(wv_o[2]), 0);
        step();
        chk("rst_add_wv", 64'(wv_o[2]), 1);
        chk("rst_add_alu", alu_o[2], 64'h1234);
        chk("rst_add_rw", 64'(rw_o[2]), 1);
        chk("rst_add_wreg", 64'(wr_o[2]), 7);
        ex = ld(64'h30, 5'd8);
        step();
        ex = bubble();
        wait_wb(10, "rst_ld_timeout");
        chk("rst_ld_rdata", rd_o[2], 0);

        rand_run(0, 300);
        rand_run(1, 300);
        rand_run(2, 300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- EX/MEM pipeline register plus memory-access stage. Sits directly downstream of the ALU.
- Captures the ALU result, the zero flag, store data and control from EX.
- Performs LDUR/STUR against an internal doubleword data memory with configurable access latency, stalling upstream while an access is pending.
- Resolves CBZ/B and drives the MEM/WB register consumed by writeback.

Parameters:
WORD, 64, datapath width (matches `WORD)
MEM_DEPTH, 64, number of WORD-wide data memory entries (power of 2)
MEM_LATENCY, 0, extra wait cycles per load/store (0..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
ex_valid  in  1  EX holds a valid instruction
ex_alu_result  in  WORD  ALU result (address for loads/stores)
ex_zero  in  1  ALU zero flag
ex_write_data  in  WORD  store data (Rt value)
ex_branch_target  in  WORD  computed branch target PC
ex_branch  in  1  conditional branch (CBZ)
ex_uncond_branch  in  1  unconditional branch (B)
ex_mem_read  in  1  load
ex_mem_write  in  1  store
ex_mem_to_reg  in  1  writeback selects memory data
ex_reg_write  in  1  instruction writes the register file
ex_write_reg  in  5  destination register
flush  in  1  kill the instruction held in EX/MEM
stall  out  1  EX/MEM cannot accept; upstream must hold
pc_src  out  1  take branch
branch_target  out  WORD  target PC when pc_src=1
wb_valid  out  1  MEM/WB holds a valid instruction
wb_read_data  out  WORD  loaded data
wb_alu_result  out  WORD  forwarded ALU result
wb_write_reg  out  5  destination register
wb_reg_write  out  1  register write enable (gated by wb_valid)
wb_mem_to_reg  out  1  writeback mux select

Behaviour:
- Reset values: all internal registers and all outputs are 0; FSM is IDLE; wait counter is 0; all memory entries are cleared to 0.
- EX/MEM load condition: at each edge with stall=0, EX/MEM loads every ex_* input, and m_valid is set to ex_valid.
- EX/MEM hold: with stall=1, EX/MEM holds its contents.
- Flush:
  - flush=1 clears m_valid at the edge and overrides both stall and the load condition.
  - A pending access is aborted: a store is not committed and the FSM returns to IDLE.
- Memory op definition: m_valid & (m_mem_read | m_mem_write).
- If both mem_read and mem_write are set, the instruction is treated as a store only.
- Addressing:
  - Index = m_alu_result[log2(MEM_DEPTH)+2:3].
  - Bits [2:0] are ignored.
  - Upper bits are ignored, so addresses wrap modulo MEM_DEPTH*8.
- FSM states:
  - IDLE: no pending memory op.
  - WAIT: count < MEM_LATENCY.
  - IDLE→WAIT: entered on the cycle a memory op sits in EX/MEM while MEM_LATENCY>0.
  - In WAIT, count increments each cycle.
  - WAIT→IDLE: on the completion edge, at which count resets to 0.
- Stall rule:
  - stall = memory op in EX/MEM and count < MEM_LATENCY (combinational).
  - MEM_LATENCY=0: never stalls; every op completes in one cycle.
  - A memory op occupies EX/MEM for exactly MEM_LATENCY+1 cycles.
- Completion edge: the first edge at which stall=0 with the op in EX/MEM. At that edge:
  - A store writes m_write_data to the indexed entry.
  - A load captures the entry into wb_read_data (pre-write contents; no same-cycle forwarding).
- MEM/WB capture: at each edge with stall=0 and no reset, MEM/WB captures m_alu_result, m_write_reg, m_mem_to_reg, and m_reg_write&m_valid, and wb_valid is set to m_valid.
- Bubbles: while stall=1, wb_valid=0 and wb_reg_write=0, so a bubble is injected and no duplicate writeback occurs.
- Branch resolution (combinational from EX/MEM):
  - pc_src = m_valid & (m_uncond_branch | (m_branch & m_zero)).
  - branch_target = m_branch_target.
  - pc_src is forced to 0 while flush=1.
  - Killing younger instructions is the hazard unit's job, not this block's.
- Non-memory, non-branch instructions pass from EX/MEM to MEM/WB in one cycle.
- Reset mid-access: the store is discarded and all state returns to its reset values at that edge.
- Back-to-back memory ops:
  - The next op loads on the completion edge.
  - It begins its own WAIT with no idle cycle between the two ops.
- Total latency: ex→wb is 2 edges for non-memory ops and 2+MEM_LATENCY edges for memory ops.

Test Plan:
- MEM_LATENCY=0: STUR at addr 0x10 with data 0xDEADBEEF_00000001, then LDUR at 0x10 with mem_to_reg=1 → two edges later wb_read_data=0xDEADBEEF_00000001, wb_valid=1, stall never asserted.
- MEM_LATENCY=3: a single LDUR → stall high for exactly 3 cycles; wb_valid=0 during those 3 cycles; the load completes on the 4th edge with one wb_valid pulse; the upstream-held instruction loads on the completion edge.
- CBZ: ex_branch=1, ex_zero=1, target 0x40 → pc_src=1 and branch_target=0x40 for exactly one cycle. Same with ex_zero=0 → pc_src=0. B with ex_zero=0 → pc_src=1.
- MEM_LATENCY=2: STUR 0x55 at addr 0x8, flush asserted during WAIT → entry 1 remains 0 (confirmed by a later LDUR at 0x8), stall drops the cycle after flush, wb_valid never set for the store.
- Address wrap with MEM_DEPTH=64: STUR at 0x200+0x18 writes entry 3; LDUR at 0x1B returns the same data because the low bits are ignored.
- Reset asserted during WAIT of a store, then released → all outputs 0, the stored entry stays 0, and the next ADD result passes to wb_alu_result two edges after issue.
